// File: rtl/tlp_tx_arbiter_if.sv
// AXI-Stream beat bundle shared by the arbiter's source ports and its core-facing port.
`timescale 1ns/1ps
interface tlp_tx_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/tlp_tx_arbiter.sv
// Packet-granular round-robin arbiter muxing two TLP sources onto the PCI-E core TX stream,
// with buffer-availability throttling and config-request servicing between packets.
`timescale 1ns/1ps
module tlp_tx_arbiter #(
  parameter int BUF_AV_MIN = 2,
  parameter int CNT_W      = 16
) (
  input  logic             user_clk,
  input  logic             s_aresetn,
  input  logic             enable,
  input  logic [5:0]       tx_buf_av,
  input  logic             tx_cfg_req,
  output logic             tx_cfg_gnt,
  tlp_tx_arbiter_if.slave  s0,
  tlp_tx_arbiter_if.slave  s1,
  tlp_tx_arbiter_if.master m,
  input  logic             tx_err_drop,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [5:0] BUF_MIN = 6'(BUF_AV_MIN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CFG  = 2'd1,
    PKT0 = 2'd2,
    PKT1 = 2'd3
  } state_t;

  state_t           state_reg;
  logic             last_grant_reg;
  logic             cfg_gnt_reg;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic [CNT_W-1:0] pkt_cnt_arr [2];

  logic [1:0] src_valid;
  logic       pick;
  logic       start_ok;
  logic       beat_last;

  assign src_valid = {s1.tvalid, s0.tvalid};
  // With both sources pending, the one not served last wins; otherwise the lone requester.
  assign pick      = (&src_valid) ? ~last_grant_reg : src_valid[1];
  assign start_ok  = enable && (tx_buf_av >= BUF_MIN) && (|src_valid);
  assign beat_last = m.tvalid && m.tready && m.tlast;

  always_ff @(posedge user_clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      cfg_gnt_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (tx_cfg_req) begin
            state_reg <= CFG;
          end else if (start_ok) begin
            state_reg      <= pick ? PKT1 : PKT0;
            last_grant_reg <= pick;
          end
        end
        CFG: begin
          if (!tx_cfg_req) begin
            state_reg   <= IDLE;
            cfg_gnt_reg <= 1'b0;
          end else begin
            cfg_gnt_reg <= 1'b1;
          end
        end
        PKT0, PKT1: begin
          // Only end-of-packet leaves a grant; cfg, enable and buffer level wait for it.
          if (beat_last) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    m.tdata   = '0;
    m.tlast   = 1'b0;
    m.tvalid  = 1'b0;
    s0.tready = 1'b0;
    s1.tready = 1'b0;
    case (state_reg)
      PKT0: begin
        m.tdata   = s0.tdata;
        m.tlast   = s0.tlast;
        m.tvalid  = s0.tvalid;
        s0.tready = m.tready;
      end
      PKT1: begin
        m.tdata   = s1.tdata;
        m.tlast   = s1.tlast;
        m.tvalid  = s1.tvalid;
        s1.tready = m.tready;
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pkt_cnt
      localparam state_t PKT_ST = (gi == 0) ? PKT0 : PKT1;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge user_clk or negedge s_aresetn) begin
        if (!s_aresetn) begin
          cnt_reg <= '0;
        end else if ((state_reg == PKT_ST) && beat_last) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign pkt_cnt_arr[gi] = cnt_reg;
    end
  endgenerate

  // Drop counter sticks at all-ones rather than wrapping so overflow stays visible.
  always_ff @(posedge user_clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      drop_cnt_reg <= '0;
    end else if (tx_err_drop && (drop_cnt_reg != '1)) begin
      drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
    end
  end

  assign tx_cfg_gnt = cfg_gnt_reg;
  assign pkt_cnt0   = pkt_cnt_arr[0];
  assign pkt_cnt1   = pkt_cnt_arr[1];
  assign drop_cnt   = drop_cnt_reg;

endmodule
